// File: rtl/pwm.sv
`default_nettype none
// ============================================================================
// Module      : pwm
// Description : Single-channel counter-based PWM with R-bit duty resolution.
//               A free-running R-bit counter sets a period of 2^R clocks. The
//               duty setting is shadowed once per period, at the last count,
//               so a change never truncates or stretches the period in
//               progress. The output is a registered unsigned compare
//               (cnt < duty_q), so 100% duty cannot be represented.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm #(
    parameter int unsigned R = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [R-1:0] duty,
    output logic         pwm_out
);

    // Counter and duty width must stay within the supported range.
    if ((R < 2) || (R > 16)) begin : g_r_range_check
        $error("pwm: R must be in the range 2..16");
    end

    localparam logic [R-1:0] CNT_ONE  = {{(R-1){1'b0}}, 1'b1};
    localparam logic [R-1:0] CNT_LAST = {R{1'b1}};

    logic [R-1:0] cnt_q;
    logic [R-1:0] cnt_d;
    logic [R-1:0] duty_q;
    logic [R-1:0] duty_d;
    logic         pwm_q;
    logic         pwm_d;
    logic         last_cycle;

    // Next-state logic: free-running wrap, end-of-period duty load, compare.
    always_comb begin
        last_cycle = (cnt_q == CNT_LAST);
        // Natural R-bit overflow gives the wrap from 2^R-1 to 0 with no idle cycle.
        cnt_d      = cnt_q + CNT_ONE;
        // The shadow only follows the input on the last count of a period, so
        // activity on duty at any other time cannot reach the output.
        duty_d     = last_cycle ? duty : duty_q;
        // Registered compare: the output lags the counter by one cycle.
        pwm_d      = (cnt_q < duty_q);
    end

    // State registers; reset clears everything without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            duty_q <= '0;
            pwm_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            duty_q <= duty_d;
            pwm_q  <= pwm_d;
        end
    end

    assign pwm_out = pwm_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm
// Description : Self-checking bench for pwm (R = 8). Each driven clock pushes
//               the expected output for the coming edge onto a queue; a
//               monitor pops and compares it one time unit after each edge.
//               Per-period high-time totals are also checked against the
//               duty value that should be in force for that period.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm;

    localparam int unsigned R = 8;
    localparam int          P = 256;

    logic         clk;
    logic         rst_n;
    logic [R-1:0] duty;
    logic         pwm_out;

    int   n_checks;
    int   n_fail;
    int   t_m;        // edges since reset release
    int   dq_m;       // duty value in force for the current period
    int   hi_cnt;     // high cycles observed in the current window
    logic exp_q[$];

    pwm #(.R(R)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .duty    (duty),
        .pwm_out (pwm_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic chk(input string tag, input int obs, input int exp_v);
        n_checks++;
        if (obs != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // Monitor: compare each edge's output against the scoreboard entry.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                logic e;
                e = exp_q.pop_front();
                chk("pwm_cycle", int'(pwm_out), int'(e));
                hi_cnt += int'(pwm_out);
            end
        end
    end

    // Drive one clock worth of duty and push the expected output of the edge.
    task automatic cycle(input logic [R-1:0] d);
        int cm;
        @(negedge clk);
        duty = d;
        if (!rst_n) begin
            exp_q.push_back(1'b0);
        end else begin
            cm = t_m % P;
            exp_q.push_back(cm < dq_m);
            if (cm == P - 1) dq_m = int'(d);
            t_m++;
        end
        @(posedge clk);
        #2;
    endtask

    // One aligned period; rnd scrambles duty on every cycle but the load cycle.
    task automatic run_period(input string tag, input logic [R-1:0] d,
                              input bit rnd, input int exp_hi);
        hi_cnt = 0;
        for (int i = 0; i < P; i++) begin
            if (rnd && (i != P - 1)) cycle(R'($urandom_range(0, P - 1)));
            else                     cycle(d);
        end
        chk(tag, hi_cnt, exp_hi);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "tb_pwm watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        t_m      = 0;
        dq_m     = 0;
        hi_cnt   = 0;
        duty     = R'(64);
        rst_n    = 1'b1;
        #1;
        rst_n    = 1'b0;
        #1;
        chk("rst_state", int'(pwm_out), 0);
        repeat (3) cycle(R'(64));
        rst_n = 1'b1;

        // Duty 64 from reset, then 128 and 192 changes at period boundaries.
        run_period("p1_d64_low",  R'(64),  1'b0, 0);
        run_period("p2_d64",      R'(64),  1'b0, 64);
        run_period("p3_chg128",   R'(128), 1'b0, 64);
        run_period("p4_d128",     R'(128), 1'b0, 128);
        run_period("p5_chg192",   R'(192), 1'b0, 128);
        run_period("p6_d192",     R'(192), 1'b0, 192);

        // Zero duty: constant low over three full periods.
        run_period("p7_chg0",     R'(0),   1'b0, 192);
        run_period("p8_d0",       R'(0),   1'b0, 0);
        run_period("p9_d0",       R'(0),   1'b0, 0);
        run_period("p10_d0",      R'(0),   1'b0, 0);

        // Maximum duty: 255 high / 1 low.
        run_period("p11_chg255",  R'(255), 1'b0, 0);
        run_period("p12_d255",    R'(255), 1'b0, 255);
        run_period("p13_d255",    R'(255), 1'b0, 255);

        // Duty scrambled every cycle; only the load-cycle value matters.
        run_period("p14_tog",     R'(100), 1'b1, 255);
        run_period("p15_tog100",  R'(37),  1'b1, 100);
        run_period("p16_tog37",   R'(200), 1'b1, 37);
        run_period("p17_tog200",  R'(128), 1'b0, 200);

        // Enter the high phase of a 128 period, then reset asynchronously.
        repeat (50) cycle(R'(128));
        #1;
        chk("pre_rst_high", int'(pwm_out), 1);
        rst_n = 1'b0;
        #1;
        chk("rst_async", int'(pwm_out), 0);
        t_m  = 0;
        dq_m = 0;
        hi_cnt = 0;
        repeat (5) cycle(R'(128));
        chk("rst_hold", hi_cnt, 0);
        rst_n = 1'b1;

        // Restart: first period low, then 128 high.
        run_period("r1_low",      R'(128), 1'b0, 0);
        run_period("r2_d128",     R'(128), 1'b0, 128);

        @(posedge clk);
        #3;
        chk("sb_drain", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
